// File: rtl/traffic_pkg.sv
`default_nettype none
// traffic_pkg: shared pedestrian-state encoding, vehicle lamp indices and a lamp helper.
// Revision: 1.0
package traffic_pkg;

   localparam logic [1:0] PED_IDLE     = 2'b00;
   localparam logic [1:0] PED_WAIT_RED = 2'b01;
   localparam logic [1:0] PED_WALK     = 2'b10;
   localparam logic [1:0] PED_FLASH    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE     = PED_IDLE,
      ST_WAIT_RED = PED_WAIT_RED,
      ST_WALK     = PED_WALK,
      ST_FLASH    = PED_FLASH
   } ped_state_t;

   localparam int LAMP_GREEN  = 0;
   localparam int LAMP_YELLOW = 1;
   localparam int LAMP_RED    = 2;
   localparam int LAMP_W      = 3;

   function automatic logic lamps_onehot(input logic [LAMP_W-1:0] l);
      return (l != '0) && ((l & (l - LAMP_W'(1))) == '0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// button_debounce: two-flop synchroniser followed by a stable-level debounce counter.
// Revision: 1.0
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 32
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic button_i,
   output logic db_lvl_o
);

   logic             sync1_q;
   logic             sync2_q;
   logic             db_lvl_q;
   logic             db_lvl_d;
   logic [CNT_W-1:0] db_cnt_q;
   logic [CNT_W-1:0] db_cnt_d;

   always_comb begin
      db_lvl_d = db_lvl_q;
      db_cnt_d = '0;
      if (sync2_q != db_lvl_q) begin
         if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db_lvl_d = sync2_q;
         end else begin
            db_cnt_d = db_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         db_lvl_q <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         sync1_q  <= button_i;
         sync2_q  <= sync1_q;
         db_lvl_q <= db_lvl_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   assign db_lvl_o = db_lvl_q;

endmodule
`default_nettype wire

// File: rtl/ped_crossing_ctrl.sv
`default_nettype none
// ped_crossing_ctrl: pedestrian Walk/DontWalk sequencer slaved to the vehicle red phase.
// Revision: 1.0
module ped_crossing_ctrl
   import traffic_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int WALK_CYCLES     = 300000000,
   parameter int FLASH_CYCLES    = 200000000,
   parameter int FLASH_HALF      = 50000000,
   parameter int CNT_W           = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic button,
   input  logic Green,
   input  logic Yellow,
   input  logic Red,
   output logic Walk,
   output logic DontWalk,
   output logic ReqPending,
   output logic Fault
);

   logic              db_lvl;
   logic              db_prev_q;
   logic              red_q;
   logic [1:0]        arm_q;
   ped_state_t        state_q, state_d;
   logic [CNT_W-1:0]  timer_q, timer_d;
   logic [CNT_W-1:0]  flash_q, flash_d;
   logic              walk_q, walk_d;
   logic              dw_q, dw_d;
   logic              req_q, req_d;
   logic              fault_q, fault_d;
   logic [LAMP_W-1:0] lamps;
   logic              db_rise;
   logic              red_rise;
   logic              lamp_fault;

   button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_debounce (
      .clk_i    (clk),
      .rst_ni   (reset),
      .button_i (button),
      .db_lvl_o (db_lvl)
   );

   assign lamps[LAMP_GREEN]  = Green;
   assign lamps[LAMP_YELLOW] = Yellow;
   assign lamps[LAMP_RED]    = Red;

   assign db_rise  = db_lvl & ~db_prev_q;
   assign red_rise = Red & ~red_q;

   // A clean hand-over from Red to Green/Yellow ends the phase early; only a
   // lamp that lights alongside Red during Walk is a conflict.
   assign lamp_fault = ((arm_q == 2'd2) && !lamps_onehot(lamps)) ||
                       ((state_q == ST_WALK) && Red && (Green || Yellow));

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      flash_d = flash_q;
      walk_d  = walk_q;
      dw_d    = dw_q;
      req_d   = req_q;
      fault_d = fault_q | lamp_fault;

      if (fault_d) begin
         state_d = ST_IDLE;
         timer_d = '0;
         flash_d = '0;
         walk_d  = 1'b0;
         dw_d    = 1'b1;
         req_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               walk_d = 1'b0;
               dw_d   = 1'b1;
               req_d  = req_q | db_rise;
               if (req_q) begin
                  state_d = ST_WAIT_RED;
               end
            end
            ST_WAIT_RED: begin
               if (red_rise) begin
                  state_d = ST_WALK;
                  req_d   = 1'b0;
                  timer_d = CNT_W'(WALK_CYCLES - 1);
                  walk_d  = 1'b1;
                  dw_d    = 1'b0;
               end
            end
            ST_WALK: begin
               if (!Red) begin
                  state_d = ST_IDLE;
                  timer_d = '0;
                  walk_d  = 1'b0;
                  dw_d    = 1'b1;
               end else if (timer_q == '0) begin
                  state_d = ST_FLASH;
                  timer_d = CNT_W'(FLASH_CYCLES - 1);
                  flash_d = CNT_W'(FLASH_HALF - 1);
                  walk_d  = 1'b0;
                  dw_d    = 1'b1;
               end else begin
                  timer_d = timer_q - CNT_W'(1);
               end
            end
            ST_FLASH: begin
               if (!Red || (timer_q == '0)) begin
                  state_d = ST_IDLE;
                  timer_d = '0;
                  flash_d = '0;
                  walk_d  = 1'b0;
                  dw_d    = 1'b1;
               end else begin
                  timer_d = timer_q - CNT_W'(1);
                  if (flash_q == '0) begin
                     dw_d    = ~dw_q;
                     flash_d = CNT_W'(FLASH_HALF - 1);
                  end else begin
                     flash_d = flash_q - CNT_W'(1);
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               walk_d  = 1'b0;
               dw_d    = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         timer_q   <= '0;
         flash_q   <= '0;
         walk_q    <= 1'b0;
         dw_q      <= 1'b1;
         req_q     <= 1'b0;
         fault_q   <= 1'b0;
         db_prev_q <= 1'b0;
         red_q     <= 1'b0;
         arm_q     <= 2'd0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         flash_q   <= flash_d;
         walk_q    <= walk_d;
         dw_q      <= dw_d;
         req_q     <= req_d;
         fault_q   <= fault_d;
         db_prev_q <= db_lvl;
         red_q     <= Red;
         // Lamp checking is blanked for the first two edges after reset release.
         if (arm_q != 2'd2) begin
            arm_q <= arm_q + 2'd1;
         end
      end
   end

   assign Walk       = walk_q;
   assign DontWalk   = dw_q;
   assign ReqPending = req_q;
   assign Fault      = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_ped_crossing_ctrl.sv
`default_nettype none
// tb_ped_crossing_ctrl: directed plus randomized stimulus against a time-based crossing model.
// Revision: 1.0
module tb_ped_crossing_ctrl;

   localparam int D_C = 4;
   localparam int W_C = 10;
   localparam int F_C = 8;
   localparam int H_C = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic button = 1'b0;
   logic Green = 1'b0;
   logic Yellow = 1'b0;
   logic Red = 1'b1;
   logic Walk, DontWalk, ReqPending, Fault;

   ped_crossing_ctrl #(
      .DEBOUNCE_CYCLES (D_C),
      .WALK_CYCLES     (W_C),
      .FLASH_CYCLES    (F_C),
      .FLASH_HALF      (H_C),
      .CNT_W           (32)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .button     (button),
      .Green      (Green),
      .Yellow     (Yellow),
      .Red        (Red),
      .Walk       (Walk),
      .DontWalk   (DontWalk),
      .ReqPending (ReqPending),
      .Fault      (Fault)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   // Reference model state: crossing expressed as a start time plus elapsed arithmetic.
   int         m_n = 0;
   int         m_start;
   int         m_run;
   int         m_rel;
   logic [1:0] m_hist;
   logic       m_lvl, m_lvl_prev, m_red_prev;
   logic       m_cross, m_wait, m_req, m_fault;
   logic       m_walk, m_dw;

   int lamp_ph = 0;
   int lamp_left = 0;
   int btn_left = 0;

   task automatic chk(input string tag, input logic got, input logic exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0b want=%0b at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_rel = 0; m_hist = '0;
      m_lvl = 0; m_lvl_prev = 0; m_red_prev = 0;
      m_cross = 0; m_wait = 0; m_req = 0; m_fault = 0;
      m_walk = 0; m_dw = 1; m_start = 0;
   endtask

   task automatic model_edge();
      logic bs, rise, redrise, bad, onehot, in_walk;
      int e;
      m_n++;
      bs = m_hist[1];
      m_hist = {m_hist[0], button};
      rise = m_lvl && !m_lvl_prev;
      m_lvl_prev = m_lvl;
      if (bs != m_lvl) begin
         m_run++;
         if (m_run == D_C) begin
            m_lvl = bs;
            m_run = 0;
         end
      end else begin
         m_run = 0;
      end
      redrise = Red && !m_red_prev;
      m_red_prev = Red;
      onehot = (int'(Green) + int'(Yellow) + int'(Red)) == 1;
      in_walk = m_cross && ((m_n - m_start) <= W_C);
      bad = ((m_rel >= 2) && !onehot) || (in_walk && Red && (Green || Yellow));
      if (m_rel < 2) m_rel++;
      if (m_fault || bad) begin
         m_fault = 1; m_cross = 0; m_wait = 0; m_req = 0;
      end else if (m_cross) begin
         e = m_n - m_start;
         if (!Red || e == W_C + F_C) m_cross = 0;
      end else if (m_wait && redrise) begin
         m_cross = 1; m_start = m_n; m_wait = 0; m_req = 0;
      end else begin
         if (m_req) m_wait = 1;
         m_req = m_req || rise;
      end
      if (m_cross) begin
         e = m_n - m_start;
         m_walk = (e < W_C);
         m_dw = (e < W_C) ? 1'b0 : ((((e - W_C) / H_C) % 2) == 0);
      end else begin
         m_walk = 0;
         m_dw = 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) model_edge();
      @(negedge clk);
      chk("walk", Walk, m_walk);
      chk("dontwalk", DontWalk, m_dw);
      chk("reqpending", ReqPending, m_req);
      chk("fault", Fault, m_fault);
      chk("walk_dw_excl", Walk & DontWalk, 1'b0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic set_lamps(input logic g, input logic y, input logic r);
      Green = g; Yellow = y; Red = r;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      model_reset();
      chk("arst_walk", Walk, 1'b0);
      chk("arst_dw", DontWalk, 1'b1);
      chk("arst_req", ReqPending, 1'b0);
      chk("arst_fault", Fault, 1'b0);
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic rand_inputs(input int fault_rate);
      if (lamp_left <= 0) begin
         lamp_ph = (lamp_ph + 1) % 3;
         case (lamp_ph)
            0:       lamp_left = int'($urandom_range(4, 25));
            1:       lamp_left = int'($urandom_range(1, 3));
            default: lamp_left = int'($urandom_range(3, 30));
         endcase
      end
      lamp_left--;
      set_lamps(lamp_ph == 0, lamp_ph == 1, lamp_ph == 2);
      if (fault_rate > 0 && $urandom_range(1, fault_rate) == 1) begin
         {Green, Yellow, Red} = 3'($urandom_range(0, 7));
      end
      if (btn_left <= 0) begin
         button = ~button;
         btn_left = int'($urandom_range(1, 12));
      end
      btn_left--;
   endtask

   initial begin
      logic dw_pat [8];
      dw_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      model_reset();
      ticks(3);
      chk("rst_walk", Walk, 1'b0);
      chk("rst_dw", DontWalk, 1'b1);
      chk("rst_req", ReqPending, 1'b0);
      chk("rst_fault", Fault, 1'b0);
      reset = 1'b1;
      ticks(20);
      chk("idle_req", ReqPending, 1'b0);

      // Bounce then stable press: request after exactly seven edges.
      button = 1; tick(); button = 0; tick();
      button = 1; tick(); button = 0; tick();
      button = 1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk("req_latency", ReqPending, i == 7);
      end

      // Full crossing on the next red rise.
      set_lamps(1, 0, 0); ticks(5);
      set_lamps(0, 1, 0); ticks(2);
      set_lamps(0, 0, 1);
      for (int i = 0; i < W_C; i++) begin
         tick();
         chk("walk_steady", Walk, 1'b1);
      end
      for (int i = 0; i < F_C; i++) begin
         tick();
         chk("flash_walk", Walk, 1'b0);
         chk("flash_pattern", DontWalk, dw_pat[i]);
      end
      tick();
      chk("post_dw", DontWalk, 1'b1);
      chk("held_no_rereq", ReqPending, 1'b0);

      // Red ends early during Walk.
      button = 0; set_lamps(1, 0, 0); ticks(8);
      button = 1; ticks(8);
      chk("req_green", ReqPending, 1'b1);
      set_lamps(0, 0, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("early_walk", Walk, 1'b1);
      end
      set_lamps(1, 0, 0);
      tick();
      chk("early_walk_off", Walk, 1'b0);
      chk("early_dw", DontWalk, 1'b1);
      chk("early_nofault", Fault, 1'b0);

      // Green together with Red: sticky fault.
      button = 0; ticks(8);
      button = 1; ticks(8);
      set_lamps(1, 0, 1);
      tick();
      chk("fault_set", Fault, 1'b1);
      for (int i = 0; i < 20; i++) begin
         rand_inputs(3);
         tick();
         chk("fault_sticky", Fault, 1'b1);
         chk("fault_nowalk", Walk, 1'b0);
      end

      // Asynchronous reset in the middle of Walk.
      button = 0; set_lamps(1, 0, 0);
      do_reset();
      ticks(4);
      button = 1; ticks(8);
      set_lamps(0, 0, 1); ticks(4);
      chk("pre_arst_walk", Walk, 1'b1);
      button = 0;
      do_reset();
      ticks(5);
      set_lamps(1, 0, 0); ticks(5);
      set_lamps(0, 0, 1); ticks(15);
      chk("fresh_walk", Walk, 1'b0);
      chk("fresh_req", ReqPending, 1'b0);

      // Randomized episodes, some with lamp corruption.
      for (int ep = 0; ep < 6; ep++) begin
         do_reset();
         for (int c = 0; c < 500; c++) begin
            rand_inputs((ep % 3 == 2) ? 60 : 0);
            tick();
         end
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
